aes_key_schedule_seq: RTL and testbench

//  Sequential, runtime-selectable AES key expansion for AES-128/192/256 (FIPS-197).

---
 rtl/aes_key_schedule_seq_if.sv | 21 ++
 rtl/aes_key_schedule_seq.sv | 128 ++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_seq_if.sv
// aes_key_schedule_seq_if: control, key load and round-key read bundle for the AES key schedule
interface aes_key_schedule_seq_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] user_key;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [3:0]   nr;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  modport master (
    output start, key_len, user_key, rk_rd_idx,
    input  busy, done, err, keys_valid, nr, rk_rd_data
  );
  modport slave (
    input  start, key_len, user_key, rk_rd_idx,
    output busy, done, err, keys_valid, nr, rk_rd_data
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: one-word-per-cycle AES-128/192/256 key expansion with registered round-key read port
module aes_key_schedule_seq #(
  parameter int MAX_NK  = 8,
  parameter bit REVERSE = 1'b0
) (
  input logic clk,
  input logic rst,
  aes_key_schedule_seq_if.slave bus
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t       state_q, state_d;
  logic [31:0]  w_q [60];
  logic [31:0]  w_d [60];
  logic [5:0]   i_q, i_d;
  logic [3:0]   nk_q, nk_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   nr_q, nr_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d, kv_q, kv_d;
  logic [127:0] rd_q, rd_d;
  logic [3:0]   nk_in, rd_r;
  logic [5:0]   rd_b;
  logic [31:0]  prev, temp;
  logic         legal, last;
  // j tracks i mod Nk and rcon the current round constant, so no divider is needed
  always_comb begin
    nk_in = bus.key_len == 2'd0 ? 4'd4 : bus.key_len == 2'd1 ? 4'd6 : 4'd8;
    legal = bus.key_len != 2'd3 && int'(nk_in) <= MAX_NK;
    prev = w_q[i_q - 6'd1];
    temp = j_q == 3'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0} :
           (nk_q == 4'd8 && j_q == 3'd4) ? sub_word(prev) : prev;
    last = i_q == {nr_q, 2'b00} + 6'd3;
    state_d = state_q;
    w_d = w_q;
    i_d = i_q;
    nk_d = nk_q;
    j_d = j_q;
    rcon_d = rcon_q;
    nr_d = nr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    kv_d = kv_q;
    if (state_q == IDLE && bus.start) begin
      if (legal) begin
        for (int k = 0; k < 8; k++)
          if (k < int'(nk_in)) w_d[k] = bus.user_key[255 - 32*k -: 32];
        i_d = {2'b00, nk_in};
        nk_d = nk_in;
        j_d = 3'd0;
        rcon_d = 8'h01;
        nr_d = nk_in + 4'd6;
        kv_d = 1'b0;
        busy_d = 1'b1;
        state_d = EXPAND;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == EXPAND) begin
      w_d[i_q] = w_q[i_q - {2'b00, nk_q}] ^ temp;
      i_d = i_q + 6'd1;
      j_d = {1'b0, j_q} == nk_q - 4'd1 ? 3'd0 : j_q + 3'd1;
      rcon_d = j_q == 3'd0 ? {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00) : rcon_q;
      if (last) begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
        kv_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    rd_r = REVERSE ? nr_q - bus.rk_rd_idx : bus.rk_rd_idx;
    rd_b = {rd_r, 2'b00};
    rd_d = (nr_q == 4'd0 || bus.rk_rd_idx > nr_q) ? '0 :
           {w_q[rd_b], w_q[rd_b + 6'd1], w_q[rd_b + 6'd2], w_q[rd_b + 6'd3]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      nk_q <= 4'd4;
      j_q <= '0;
      rcon_q <= 8'h01;
      nr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      kv_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      nk_q <= nk_d;
      j_q <= j_d;
      rcon_q <= rcon_d;
      nr_q <= nr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      kv_q <= kv_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) w_q <= w_d;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.keys_valid = kv_q;
  assign bus.nr = nr_q;
  assign bus.rk_rd_data = rd_q;
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: FIPS-197 directed vectors with a queue scoreboard and decoupled monitor
module tb_aes_key_schedule_seq;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam int RD = 0, BUSY = 1, KV = 2, NR = 3, ERR = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic start_m = 1'b0, start_s = 1'b0;
  logic [1:0] key_len = 2'd0;
  logic [255:0] user_key = '0;
  logic [3:0] idx = 4'd0;
  int cycle = 0, t_acc = 0, checks = 0, errors = 0, err_exp = 0;
  typedef struct {string nm; int dut; int fld; logic [127:0] exp; int due;} probe_t;
  typedef struct {int cyc; logic [3:0] nr;} done_t;
  probe_t pq[$];
  done_t dq[$];
  aes_key_schedule_seq_if if_m ();
  aes_key_schedule_seq_if if_r ();
  aes_key_schedule_seq_if if_s ();
  aes_key_schedule_seq #(.MAX_NK(8), .REVERSE(1'b0)) u_main (.clk(clk), .rst(rst), .bus(if_m.slave));
  aes_key_schedule_seq #(.MAX_NK(8), .REVERSE(1'b1)) u_rev (.clk(clk), .rst(rst), .bus(if_r.slave));
  aes_key_schedule_seq #(.MAX_NK(4), .REVERSE(1'b0)) u_small (.clk(clk), .rst(rst), .bus(if_s.slave));
  assign if_m.start = start_m;
  assign if_m.key_len = key_len;
  assign if_m.user_key = user_key;
  assign if_m.rk_rd_idx = idx;
  assign if_r.start = start_m;
  assign if_r.key_len = key_len;
  assign if_r.user_key = user_key;
  assign if_r.rk_rd_idx = idx;
  assign if_s.start = start_m | start_s;
  assign if_s.key_len = key_len;
  assign if_s.user_key = user_key;
  assign if_s.rk_rd_idx = idx;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cycle);
    $fatal(1);
  end
  function automatic logic [127:0] get(input int d, input int f);
    logic [127:0] rd;
    logic [3:0] nr;
    logic b, kv, e;
    rd = d == 0 ? if_m.rk_rd_data : d == 1 ? if_r.rk_rd_data : if_s.rk_rd_data;
    nr = d == 0 ? if_m.nr : d == 1 ? if_r.nr : if_s.nr;
    b = d == 0 ? if_m.busy : d == 1 ? if_r.busy : if_s.busy;
    kv = d == 0 ? if_m.keys_valid : d == 1 ? if_r.keys_valid : if_s.keys_valid;
    e = d == 0 ? if_m.err : d == 1 ? if_r.err : if_s.err;
    return f == RD ? rd : f == BUSY ? {127'b0, b} : f == KV ? {127'b0, kv} : f == NR ? {124'b0, nr} : {127'b0, e};
  endfunction
  // monitor: drains due probes, and matches every done/err pulse of the main DUT against the scoreboard
  always @(negedge clk) begin
    probe_t p;
    done_t d;
    logic [127:0] act;
    while (pq.size() > 0 && pq[0].due <= cycle) begin
      p = pq.pop_front();
      act = get(p.dut, p.fld);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", p.nm, act, p.exp);
      end
    end
    if (if_m.done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_spurious: got done=1 required no done (cycle %0d)", cycle - t_acc + 1);
      end else begin
        d = dq.pop_front();
        if (cycle - t_acc + 1 != d.cyc || if_m.nr !== d.nr) begin
          errors++;
          $display("FAIL done_timing: got cycle %0d nr %0d required cycle %0d nr %0d",
                   cycle - t_acc + 1, if_m.nr, d.cyc, d.nr);
        end
      end
    end
    if (if_m.err === 1'b1) begin
      checks++;
      if (err_exp == 0) begin
        errors++;
        $display("FAIL err_spurious: got err=1 required err=0");
      end else err_exp--;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic probe(input string nm, input int d, input int f, input logic [127:0] e);
    pq.push_back('{nm, d, f, e, cycle + 1});
  endtask
  task automatic rdp(input string nm, input int d, input logic [3:0] i, input logic [127:0] e);
    idx = i;
    probe(nm, d, RD, e);
    step();
  endtask
  task automatic run(input logic [1:0] kl, input logic [255:0] k, input int ecyc, input logic [3:0] enr, input int pulse);
    bit seen;
    start_m = 1'b1;
    key_len = kl;
    user_key = k;
    dq.push_back('{ecyc, enr});
    step();
    t_acc = cycle;
    start_m = 1'b0;
    key_len = 2'd3;
    user_key = ~k;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (pulse != 0 && cycle - t_acc + 1 == pulse) begin
        start_m = 1'b1;
        key_len = 2'd0;
        user_key = {8{32'hdeadbeef}};
      end else start_m = 1'b0;
      step();
      seen = if_m.done;
    end
    start_m = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done required done at cycle %0d", ecyc);
    end
    step();
  endtask
  initial begin
    repeat (2) step();
    probe("rst_busy", 0, BUSY, 0);
    probe("rst_kv", 0, KV, 0);
    probe("rst_nr", 0, NR, 0);
    probe("rst_rd", 0, RD, 0);
    probe("rst_err", 0, ERR, 0);
    step();
    rst = 1'b0;
    rdp("nokey_rd0", 0, 4'd0, 0);
    // 1: AES-128
    run(2'd0, K128, 41, 4'd10, 0);
    rdp("a128_idx0", 0, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rdp("a128_idx1", 0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rdp("a128_idx10", 0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rdp("a128_rev_idx0", 1, 4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    probe("a128_kv", 0, KV, 1);
    probe("a128_nr", 0, NR, 10);
    rdp("a128_idx11", 0, 4'd11, 0);
    // 2: AES-192
    run(2'd1, K192, 47, 4'd12, 0);
    rdp("a192_idx0", 0, 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    rdp("a192_idx12", 0, 4'd12, 128'he98ba06f448c773c8ecc720401002202);
    probe("a192_nr", 0, NR, 12);
    rdp("a192_idx13", 0, 4'd13, 0);
    // 3: AES-256
    run(2'd2, K256, 53, 4'd14, 0);
    rdp("a256_idx14", 0, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    rdp("a256_rev_idx0", 1, 4'd0, 128'hfe4890d1e6188d0b046df344706c631e);
    rdp("a256_rev_idx14", 1, 4'd14, 128'h603deb1015ca71be2b73aef0857d7781);
    rdp("a256_idx15", 0, 4'd15, 0);
    // 4: rejected starts
    start_m = 1'b1;
    key_len = 2'd3;
    err_exp++;
    probe("ill_err", 0, ERR, 1);
    probe("ill_busy", 0, BUSY, 0);
    probe("ill_small_err", 2, ERR, 1);
    step();
    start_m = 1'b0;
    probe("ill_err_drop", 0, ERR, 0);
    probe("ill_kv", 0, KV, 1);
    probe("ill_nr", 0, NR, 14);
    step();
    start_s = 1'b1;
    key_len = 2'd2;
    user_key = K256;
    probe("maxnk_err", 2, ERR, 1);
    probe("maxnk_busy", 2, BUSY, 0);
    step();
    start_s = 1'b0;
    probe("maxnk_kv", 2, KV, 1);
    probe("maxnk_nr", 2, NR, 10);
    probe("maxnk_main_busy", 0, BUSY, 0);
    step();
    // 5: start during EXPAND is ignored
    run(2'd0, K128, 41, 4'd10, 5);
    rdp("ign_idx1", 0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rdp("ign_idx10", 0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rdp("ign_idx11", 0, 4'd11, 0);
    // 6: reset mid-expansion, with a simultaneous start
    start_m = 1'b1;
    key_len = 2'd2;
    user_key = K256;
    step();
    t_acc = cycle;
    start_m = 1'b0;
    while (cycle - t_acc + 1 < 20) step();
    rst = 1'b1;
    start_m = 1'b1;
    key_len = 2'd0;
    user_key = K128;
    probe("abort_busy", 0, BUSY, 0);
    probe("abort_kv", 0, KV, 0);
    probe("abort_nr", 0, NR, 0);
    step();
    rst = 1'b0;
    start_m = 1'b0;
    probe("abort_stay_idle", 0, BUSY, 0);
    step();
    run(2'd0, K128, 41, 4'd10, 0);
    rdp("rerun_idx1", 0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rdp("rerun_idx10", 0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (3) step();
    checks++;
    if (pq.size() != 0 || dq.size() != 0 || err_exp != 0) begin
      errors++;
      $display("FAIL leftover: got %0d probes %0d dones %0d errs pending required 0",
               pq.size(), dq.size(), err_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
